// File: rtl/rsa_modmult_radix.sv
// Interleaved modular multiplier, STEP multiplier bits per clock: product = (mpand*mplier) mod modulus.
// Optional build macro MODMULT_CYCLE_CNT_EN adds the 16-bit 'cycles' output reporting RUN cycles of the last op.
module rsa_modmult_radix #(
    parameter int MPWID = 1024,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ds,
    input  logic [MPWID-1:0] mpand,
    input  logic [MPWID-1:0] mplier,
    input  logic [MPWID-1:0] modulus,
    output logic             ready,
    output logic             done,
    output logic [MPWID-1:0] product,
    output logic             err
`ifdef MODMULT_CYCLE_CNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    generate
        if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
            $error("rsa_modmult_radix: STEP must be 1, 2, 4 or 8");
        end
        if (MPWID < 8) begin : g_bad_width
            $error("rsa_modmult_radix: MPWID must be at least 8");
        end
    endgenerate

    logic [0:0]       state;
    logic [MPWID-1:0] mpreg;
    logic [MPWID-1:0] mcreg;
    logic [MPWID-1:0] modreg;
    logic [MPWID-1:0] prodreg;
    logic [MPWID-1:0] prodNext;
    logic [MPWID-1:0] mcNext;
    logic [MPWID+1:0] pAcc;
    logic [MPWID+1:0] mcAcc;
    logic [MPWID+1:0] modExt;
    logic             badOperands;

    assign ready       = (state == IDLE);
    assign badOperands = (modulus == '0) || (mpand >= modulus);

    // Unrolled sub-steps; two guard bits keep p+mc and 2*mc exact before the conditional subtract.
    always_comb begin
        modExt = {2'b00, modreg};
        pAcc   = {2'b00, prodreg};
        mcAcc  = {2'b00, mcreg};
        for (int i = 0; i < STEP; i++) begin
            if (mpreg[i]) begin
                pAcc = pAcc + mcAcc;
            end
            if (pAcc >= modExt) begin
                pAcc = pAcc - modExt;
            end
            mcAcc = {mcAcc[MPWID:0], 1'b0};
            if (mcAcc >= modExt) begin
                mcAcc = mcAcc - modExt;
            end
        end
        prodNext = pAcc[MPWID-1:0];
        mcNext   = mcAcc[MPWID-1:0];
    end

`ifdef MODMULT_CYCLE_CNT_EN
    logic [15:0] runCnt;
    logic [15:0] runCntInc;

    assign runCntInc = (runCnt == 16'hFFFF) ? runCnt : runCnt + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            runCnt <= '0;
            cycles <= '0;
        end else if (state == IDLE) begin
            if (ds) begin
                runCnt <= '0;
                if (badOperands) begin
                    cycles <= '0;
                end
            end
        end else begin
            runCnt <= runCntInc;
            if (mpreg == '0) begin
                cycles <= runCntInc;
            end
        end
    end
`endif

    // err is only rewritten when an op finishes, so a back-to-back accept leaves the previous result intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mpreg   <= '0;
            mcreg   <= '0;
            modreg  <= '0;
            prodreg <= '0;
            product <= '0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ds) begin
                        mpreg   <= mplier;
                        mcreg   <= mpand;
                        modreg  <= modulus;
                        prodreg <= '0;
                        if (badOperands) begin
                            err     <= 1'b1;
                            product <= '0;
                            done    <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                default: begin
                    if (mpreg != '0) begin
                        prodreg <= prodNext;
                        mcreg   <= mcNext;
                        mpreg   <= mpreg >> STEP;
                    end else begin
                        product <= prodreg;
                        err     <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modmult_radix.sv
// Self-checking bench: four 64-bit instances (STEP 1,2,4,8) against a big-integer reference model.
module tb_rsa_modmult_radix;

    logic        clk;
    logic        reset;
    logic        ds      [4];
    logic [63:0] mpandv  [4];
    logic [63:0] mplierv [4];
    logic [63:0] modv    [4];
    logic        ready   [4];
    logic        done    [4];
    logic [63:0] productv[4];
    logic        err     [4];
`ifdef MODMULT_CYCLE_CNT_EN
    logic [15:0] cycles  [4];
`endif

    int checks = 0;
    int errors = 0;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            rsa_modmult_radix #(.MPWID(64), .STEP(1 << g)) dut (
                .clk(clk),
                .reset(reset),
                .ds(ds[g]),
                .mpand(mpandv[g]),
                .mplier(mplierv[g]),
                .modulus(modv[g]),
                .ready(ready[g]),
                .done(done[g]),
                .product(productv[g]),
                .err(err[g])
`ifdef MODMULT_CYCLE_CNT_EN
                ,
                .cycles(cycles[g])
`endif
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] refModMul(input logic [63:0] a, input logic [63:0] b,
                                               input logic [63:0] m);
        logic [127:0] full;
        full = ({64'b0, a} * {64'b0, b}) % {64'b0, m};
        return full[63:0];
    endfunction

    function automatic int bitLen(input logic [63:0] x);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (x[i]) n = i + 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One op on instance k; optionally pulses a junk ds while busy, which must have no effect.
    task automatic applyStimulus(input int k, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] m, input bit busyDs);
        logic        expErr;
        logic [63:0] expProd;
        int          stepBits;
        int          expLat;
        int          lat;
        stepBits = 1 << k;
        expErr   = (m == 64'd0) || (a >= m);
        expProd  = expErr ? 64'd0 : refModMul(a, b, m);
        expLat   = expErr ? 0 : (bitLen(b) + stepBits - 1) / stepBits + 1;
        checkOutput("ready_before_accept", {63'b0, ready[k]}, 64'd1);
        mpandv[k]  = a;
        mplierv[k] = b;
        modv[k]    = m;
        ds[k]      = 1'b1;
        @(posedge clk);
        #1;
        ds[k] = 1'b0;
        if (expLat > 0) begin
            checkOutput("ready_low_in_run", {63'b0, ready[k]}, 64'd0);
        end
        if (busyDs && expLat > 1) begin
            mpandv[k]  = 64'd20;
            mplierv[k] = 64'hFFFF;
            modv[k]    = 64'd11;
            ds[k]      = 1'b1;
        end
        lat = 0;
        while (!done[k] && lat < 200) begin
            @(posedge clk);
            #1;
            ds[k] = 1'b0;
            lat++;
        end
        checkOutput("done_seen", {63'b0, done[k]}, 64'd1);
        checkOutput("latency", 64'(lat), 64'(expLat));
        checkOutput("product", productv[k], expProd);
        checkOutput("err", {63'b0, err[k]}, {63'b0, expErr});
        checkOutput("ready_on_done", {63'b0, ready[k]}, 64'd1);
`ifdef MODMULT_CYCLE_CNT_EN
        checkOutput("cycles", {48'b0, cycles[k]}, expErr ? 64'd0 : 64'(expLat));
`endif
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] m;
        int          k;
        int          len;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ds[i]      = 1'b0;
            mpandv[i]  = '0;
            mplierv[i] = '0;
            modv[i]    = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("reset_ready", {63'b0, ready[i]}, 64'd1);
            checkOutput("reset_done", {63'b0, done[i]}, 64'd0);
            checkOutput("reset_product", productv[i], 64'd0);
            checkOutput("reset_err", {63'b0, err[i]}, 64'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1, 64'd5, 64'd7, 64'd11, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {63'b0, done[1]}, 64'd0);
        applyStimulus(1, 64'd65520, 64'd65520, 64'd65521, 1'b0);
        applyStimulus(0, 64'd9, 64'd0, 64'd13, 1'b0);
        applyStimulus(1, 64'd3, 64'd5, 64'd0, 1'b0);
        applyStimulus(1, 64'd20, 64'd5, 64'd11, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("err_done_one_cycle", {63'b0, done[1]}, 64'd0);
        applyStimulus(2, 64'd0, 64'd12345, 64'd1, 1'b0);
        applyStimulus(1, 64'd5, 64'd7, 64'd11, 1'b1);
        applyStimulus(3, 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Abort an op on instance 0 with an asynchronous reset in the middle of RUN.
        mpandv[0]  = 64'd1;
        mplierv[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        modv[0]    = 64'hFFFF_FFFF_FFFF_FFC5;
        ds[0]      = 1'b1;
        @(posedge clk);
        #1;
        ds[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midop_reset_ready", {63'b0, ready[0]}, 64'd1);
        checkOutput("midop_reset_done", {63'b0, done[0]}, 64'd0);
        checkOutput("midop_reset_product", productv[0], 64'd0);
        checkOutput("midop_reset_err", {63'b0, err[0]}, 64'd0);
`ifdef MODMULT_CYCLE_CNT_EN
        checkOutput("midop_reset_cycles", {48'b0, cycles[0]}, 64'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_done", {63'b0, done[0]}, 64'd0);

        // Random ops back to back: each new ds is raised in the done cycle of the previous op.
        for (int n = 0; n < 2000; n++) begin
            k = $urandom_range(0, 3);
            m = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) m = m >> $urandom_range(32, 60);
            if (m == 64'd0) m = 64'd1;
            a   = {$urandom, $urandom} % m;
            b   = {$urandom, $urandom};
            len = $urandom_range(0, 64);
            if (len < 64) b = b & ((64'd1 << len) - 64'd1);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    m = 64'd0;
                end else begin
                    a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
                    m = a >> $urandom_range(0, 3);
                end
            end
            applyStimulus(k, a, b, m, ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
